// File: rtl/ula_pkg.sv
// Shared types for the nibble-serial 74181 sequencer.
package ula_pkg;

  localparam int unsigned NIB_W = 4;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } ula_op_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

endpackage

// File: rtl/ula_74181.sv
// One 4-bit 74181-style ALU slice, active-high data and active-high carries.
module ula_74181
  import ula_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic [NIB_W-1:0] f,
  output logic             c_out,
  output logic             a_eq_b
);

  logic [NIB_W-1:0] t1;
  logic [NIB_W-1:0] t2;
  logic [NIB_W:0]   sum;

  // Every 74181 function is t1 plus t2 (arithmetic) or the complement of t1 xor t2 (logic).
  always_comb begin
    t1     = a | (b & {NIB_W{s[0]}}) | (~b & {NIB_W{s[1]}});
    t2     = (a & ~b & {NIB_W{s[2]}}) | (a & b & {NIB_W{s[3]}});
    sum    = {1'b0, t1} + {1'b0, t2} + {{NIB_W{1'b0}}, c_in};
    f      = m ? ~(t1 ^ t2) : sum[NIB_W-1:0];
    c_out  = sum[NIB_W];
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_nibble_seq.sv
// Widens the 4-bit ula_74181 slice to WIDTH bits by running one nibble per clock, LSB first.
module ula_nibble_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             zero
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("ula_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] f_q, f_d;
  ula_op_t          op_q, op_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIB_W-1:0] slice_a, slice_b, slice_f;
  logic             slice_c, slice_eq;

  assign slice_a = a_q[NIB_W*idx_q +: NIB_W];
  assign slice_b = b_q[NIB_W*idx_q +: NIB_W];

  ula_74181 u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .s      (op_q.s),
    .m      (op_q.m),
    .c_in   (carry_q),
    .f      (slice_f),
    .c_out  (slice_c),
    .a_eq_b (slice_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    op_d    = op_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = '{s: s, m: m};
          carry_d = c_in;
          eq_d    = 1'b1;
          idx_d   = '0;
          f_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        f_d[NIB_W*idx_q +: NIB_W] = slice_f;
        carry_d = slice_c;
        eq_d    = eq_q & slice_eq;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign c_out     = carry_q;
  assign a_eq_b    = eq_q;
  assign zero      = out_valid && (f_q == '0);

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Scoreboard bench for ula_nibble_seq against a word-level 74181 function-table model.
module tb_ula_nibble_seq;

  localparam int NIB = 4;

  typedef struct {
    logic [15:0] f;
    logic        cout;
    logic        eq;
    logic        zero;
    logic        m;
    int          acc;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, f;
  logic [3:0]  s;
  logic        m, c_in, c_out, a_eq_b, zero;

  int   nchecks = 0;
  int   nerr    = 0;
  int   cyc     = 0;
  int   or_mode = 0;  // 0 random out_ready, 1 always high, 2 held low
  int   last_acc = 0;
  int   prev_acc = 0;
  bit   seen = 0;
  exp_t sb[$];

  ula_nibble_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .c_out     (c_out),
    .a_eq_b    (a_eq_b),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (or_mode == 1)      out_ready = 1'b1;
    else if (or_mode == 2) out_ready = 1'b0;
    else                   out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Datasheet function table evaluated on whole words; carries fall out of 17-bit sums.
  function automatic exp_t model(input logic [15:0] av, bv, input logic [3:0] sv,
                                 input logic mv, cv);
    exp_t        e;
    logic [16:0] x, y, ny, ones, c, r;
    x = {1'b0, av}; y = {1'b0, bv}; ny = {1'b0, ~bv}; ones = 17'h0FFFF; c = {16'd0, cv};
    if (mv) begin
      case (sv)
        4'h0: r = ~x;         4'h1: r = ~(x | y);   4'h2: r = ~x & y;     4'h3: r = 17'd0;
        4'h4: r = ~(x & y);   4'h5: r = ~y;         4'h6: r = x ^ y;      4'h7: r = x & ny;
        4'h8: r = ~x | y;     4'h9: r = ~(x ^ y);   4'hA: r = y;          4'hB: r = x & y;
        4'hC: r = ones;       4'hD: r = x | ny;     4'hE: r = x | y;      default: r = x;
      endcase
    end else begin
      case (sv)
        4'h0: r = x + c;                 4'h1: r = (x | y) + c;
        4'h2: r = (x | ny) + c;          4'h3: r = ones + c;
        4'h4: r = x + (x & ny) + c;      4'h5: r = (x | y) + (x & ny) + c;
        4'h6: r = x + ny + c;            4'h7: r = (x & ny) + ones + c;
        4'h8: r = x + (x & y) + c;       4'h9: r = x + y + c;
        4'hA: r = (x | ny) + (x & y) + c; 4'hB: r = (x & y) + ones + c;
        4'hC: r = x + x + c;             4'hD: r = (x | y) + x + c;
        4'hE: r = (x | ny) + x + c;      default: r = x + ones + c;
      endcase
    end
    e.f = r[15:0]; e.cout = r[16]; e.eq = (r[15:0] == 16'hFFFF);
    e.zero = (r[15:0] == 16'h0000); e.m = mv; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] fv, input logic cv, ev, zv, mv);
    exp_t e;
    e.f = fv; e.cout = cv; e.eq = ev; e.zero = zv; e.m = mv; e.acc = 0;
    return e;
  endfunction

  // Offer one operation; after the accepting edge scramble the inputs so later changes are ignored.
  task automatic issue(input logic [15:0] av, bv, input logic [3:0] sv, input logic mv, cv,
                       input exp_t e, input bit keep);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; s = sv; m = mv; c_in = cv; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    prev_acc = last_acc;
    last_acc = e.acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom);
    c_in = 1'($urandom); in_valid = keep;
  endtask

  task automatic issue_rand(input bit keep);
    logic [15:0] av, bv;
    logic [3:0]  sv;
    logic        mv, cv;
    av = 16'($urandom); bv = 16'($urandom); sv = 4'($urandom);
    mv = 1'($urandom); cv = 1'($urandom);
    if ($urandom_range(0, 3) == 0) bv = av;
    issue(av, bv, sv, mv, cv, model(av, bv, sv, mv, cv), keep);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_f"},         32'(f),         32'd0);
    check({tag, "_c_out"},     32'(c_out),     32'd0);
    check({tag, "_a_eq_b"},    32'(a_eq_b),    32'd0);
    check({tag, "_zero"},      32'(zero),      32'd0);
  endtask

  // Monitor: compares every DONE cycle against the queue head, pops on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        if (!seen) check("latency", 32'(cyc - sb[0].acc), 32'(NIB));
        seen = 1;
        check("f", 32'(f), 32'(sb[0].f));
        check("a_eq_b", 32'(a_eq_b), 32'(sb[0].eq));
        check("zero", 32'(zero), 32'(sb[0].zero));
        if (!sb[0].m) check("c_out", 32'(c_out), 32'(sb[0].cout));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
    or_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Directed operations from the plan.
    issue(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, mk(16'hF000, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    issue(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
    issue(16'h1234, 16'h1234, 4'b0110, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    issue(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b0, mk(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
    drain();

    // Backpressure: hold DONE while pulsing new requests that must not be captured.
    or_mode = 2;
    issue(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, mk(16'h1011, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    or_mode = 1;
    issue(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0, mk(16'h0007, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    drain();

    // Reset in the middle of RUN (idx == 2).
    issue(16'hAAAA, 16'h5555, 4'b1001, 1'b0, 1'b0, model(16'hAAAA, 16'h5555, 4'b1001, 1'b0, 1'b0),
          1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1 check_reset_vals("midrun_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("in_ready_after_release", 32'(in_ready), 32'd1);
    issue(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    or_mode = 1;
    issue(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(16'h0FF0, 16'h00FF, 4'b1110, 1'b1, 1'b0, mk(16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    check("b2b_gap", 32'(last_acc - prev_acc), 32'(NIB + 2));
    drain();

    // Randomized traffic with random backpressure.
    or_mode = 0;
    for (int i = 0; i < 60; i++) issue_rand((i != 59) && ($urandom_range(0, 1) == 1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ula_nibble_seq.md
# ula_nibble_seq

Multi-cycle sequencer that widens the 4-bit `ula_74181` slice to a WIDTH-bit datapath. It processes one nibble per clock, least-significant first, and chains the slice carry between cycles. It sits directly upstream of the ALU slice: it drives the slice's `a`/`b`/`s`/`m`/`c_in` and consumes its `f`/`c_out`/`a_eq_b`. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8.
- NIB, WIDTH/4, number of nibble passes (derived; not overridable).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  74181 function select, applied to every nibble.
- m  input  1  mode: 0 arithmetic, 1 logic.
- c_in  input  1  active-high carry into nibble 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- f  output  WIDTH  result word.
- c_out  output  1  carry out of the last nibble (active-high).
- a_eq_b  output  1  AND of all per-nibble `a_eq_b`.
- zero  output  1  `f == 0`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready=1`.
  - On `in_valid & in_ready`: capture `a`, `b`, `s`, `m` into holding registers.
  - Set carry register to `c_in`, `idx=0`, `eq_acc=1`, clear result register, go to RUN.
- RUN: the slice sees `a_q[4*idx+:4]`, `b_q[4*idx+:4]`, `s_q`, `m_q`, `carry_q`. Each edge:
  - write slice `f` into `f_q[4*idx+:4]`;
  - `carry_q <= slice c_out`;
  - `eq_acc <= eq_acc & slice a_eq_b`;
  - `idx <= idx+1`.
  - At `idx==NIB-1`, go to DONE instead of incrementing.
- DONE: `out_valid=1`; `f`, `c_out`, `a_eq_b`, `zero` are held stable. On `out_ready`, go to IDLE.
- Carry is chained in logic mode too. `c_out` reports the last slice value regardless of `m`; the consumer ignores it in logic mode.
- Input changes outside the IDLE handshake are ignored. `s`/`m` changes never affect an operation in flight.
- `idx` width is `$clog2(NIB)`; it never wraps past NIB-1.
- `zero` is computed combinationally from the registered `f_q`.

## Timing
- Reset (async assert, sync release): state=IDLE, `in_ready=1`, `out_valid=0`, `f=0`, `c_out=0`, `a_eq_b=0`, `zero=0` (forced low outside DONE), idx=0, carry=0.
- Latency: `out_valid` rises NIB edges after the accepting edge (4 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles minimum (DONE handshake cycle plus one IDLE cycle).
- `in_ready` is low throughout RUN and DONE. An `in_valid` held high is accepted in the first IDLE cycle.
- `out_valid` stays high, with outputs frozen, until `out_ready`; no timeout.
- Reset during RUN or DONE aborts the operation and discards partial results. The state is IDLE on the first edge after release.
- All outputs are registered except `zero`, `in_ready` and `out_valid`, which decode directly from registered state.

## Structure
- Shared package `ula_pkg`:
  - `ula_op_t` struct {s[3:0], m};
  - `seq_state_t` enum {IDLE, RUN, DONE};
  - constant `NIB_W=4`.
- One sub-module: a single `ula_74181` instance (`u_slice`) driven by the nibble mux. No other hierarchy.

## Test plan
- Logic AND (m=1, s=1011), A=F0F0, B=FF00, c_in=0 -> f=F000, zero=0, out_valid exactly 4 edges after accept.
- Arithmetic A plus B (m=0, s=1001):
  - 00FF+0001, c_in=0 -> f=0100, c_out=0 (carry ripples across nibbles 0→1).
  - FFFF+0001 -> f=0000, c_out=1, zero=1.
- Logic XOR (m=1, s=0110), A=B=1234 -> f=0000, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> f/flags stable, in_ready=0, new operands not captured; next result matches the next accepted op only.
- Reset asserted mid-RUN (idx=2) -> outputs return to reset values immediately, in_ready=1 after release; the following op 1234+1111 (s=1001, m=0) -> f=2345.
- Back-to-back: in_valid and out_ready held high for two ops -> second accepted in the cycle after the first DONE handshake; both results correct with no overlap.
